mst_imp_w_ch: RTL

Write-side AXI4-lite master for the image-processing path. It sits directly downstream of the source-window read master and its processing stage. It accepts processed 32-bit pixel words on a valid/ready stream, buffers them in a small FIFO, and writes them as a HSIZE x VSIZE word rectangle to a destination base address with a row pitch. Each word is one single-beat write (AW+W, then B).

---
 rtl/mst_imp_w_ch.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mst_imp_w_ch.sv
// Write-side AXI4-lite master: drains a small pixel FIFO into an HSIZE x VSIZE
// word rectangle at a pitched destination, one single-beat write at a time.
module mst_imp_w_ch #(
  parameter int FIFO_DEPTH  = 4,
  parameter int OUTSTANDING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [31:0] pix_data,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  input  logic [1:0]  mem_axi_bresp,
  input  logic [7:0]  IMP_HSIZE,
  input  logic [7:0]  IMP_VSIZE,
  input  logic [31:0] IMP_DST_BADDR,
  input  logic [8:0]  IMP_ADR_PITCH,
  input  logic        IMP_ST,
  output logic        imp_busy,
  output logic        imp_done,
  output logic        imp_err
);
  localparam int AW = $clog2(FIFO_DEPTH);

  generate
    if (OUTSTANDING != 1) begin : g_bad_outstanding
      $error("mst_imp_w_ch: OUTSTANDING must be 1");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mst_imp_w_ch: FIFO_DEPTH must be a power of two in 2..16");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t      r_state, w_nxt;
  logic [1:0]  r_st_hist;
  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic [7:0]  r_hsize, r_vsize, r_xcnt, r_ycnt;
  logic [31:0] r_row_base, r_addr;
  logic        r_aw_done, r_w_done, r_err;

  logic        w_strt, w_empty, w_full, w_push, w_pop;
  logic        w_aw_hs, w_w_hs, w_last, w_row_end, w_both_done;
  logic [31:0] w_pitch;

  assign w_strt  = (r_st_hist == 2'b01);
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = pix_valid && pix_ready;
  assign w_pop   = w_w_hs;
  assign w_pitch = {23'd0, IMP_ADR_PITCH};

  // Once W has gone, AW must stay up even if the FIFO has since drained.
  assign mem_axi_awvalid = (r_state == S_REQ) && !r_aw_done && (r_w_done || !w_empty);
  assign mem_axi_wvalid  = (r_state == S_REQ) && !r_w_done && !w_empty;
  assign mem_axi_awaddr  = r_addr;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wdata   = w_empty ? 32'd0 : r_mem[r_rp[AW-1:0]];
  assign mem_axi_wstrb   = 4'hF;
  assign mem_axi_bready  = (r_state == S_RESP);
  assign pix_ready       = !w_full;
  assign imp_busy        = (r_state == S_REQ) || (r_state == S_RESP);
  assign imp_done        = (r_state == S_DONE);
  assign imp_err         = r_err;

  assign w_aw_hs     = mem_axi_awvalid && mem_axi_awready;
  assign w_w_hs      = mem_axi_wvalid && mem_axi_wready;
  assign w_both_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_row_end   = (r_xcnt == r_hsize - 8'd1);
  assign w_last      = w_row_end && (r_ycnt == r_vsize - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_strt) w_nxt = (IMP_HSIZE == 8'd0 || IMP_VSIZE == 8'd0) ? S_DONE : S_REQ;
      S_REQ:  if (w_both_done) w_nxt = S_RESP;
      S_RESP: if (mem_axi_bvalid) w_nxt = w_last ? S_DONE : S_REQ;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_hist  <= 2'b00;
      r_wp       <= '0;
      r_rp       <= '0;
      r_hsize    <= 8'd0;
      r_vsize    <= 8'd0;
      r_xcnt     <= 8'd0;
      r_ycnt     <= 8'd0;
      r_row_base <= 32'd0;
      r_addr     <= 32'd0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_st_hist <= {r_st_hist[0], IMP_ST};
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case (r_state)
        S_IDLE: if (w_strt) begin
          r_hsize    <= IMP_HSIZE;
          r_vsize    <= IMP_VSIZE;
          r_row_base <= IMP_DST_BADDR;
          r_addr     <= IMP_DST_BADDR;
          r_xcnt     <= 8'd0;
          r_ycnt     <= 8'd0;
          r_err      <= 1'b0;
        end
        S_REQ: begin
          if (w_both_done) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        S_RESP: if (mem_axi_bvalid) begin
          if (mem_axi_bresp != 2'b00) r_err <= 1'b1;
          if (!w_last) begin
            // Row advance uses the live pitch input.
            if (w_row_end) begin
              r_xcnt     <= 8'd0;
              r_ycnt     <= r_ycnt + 8'd1;
              r_row_base <= r_row_base + w_pitch;
              r_addr     <= r_row_base + w_pitch;
            end else begin
              r_xcnt <= r_xcnt + 8'd1;
              r_addr <= r_addr + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
